trace_run_ctrl: RTL and testbench
=================================

Name: trace_run_ctrl

Overview:
- Parametrised run-control and instruction-trace block for the single-cycle core.
- Replaces the constant PC enable with a run/halt/single-step FSM that has address breakpoints.
- Records every retired instruction, including any dmem write it performs, into a circular trace buffer drained through a valid/ready port.
- Instantiated in the top level between the core, the PC and dmem.

Parameters:
- IADDR_W, 5: instruction address width.
- INST_W, 16: instruction width.
- DADDR_W, 4: dmem address width.
- DATA_W, 8: dmem data width.
- TRACE_DEPTH, 16: trace entries; must be a power of 2 and at least 2.
- NUM_BP, 2: number of breakpoint comparators.
- CNT_W, 16: width of the retired-instruction counter.
- START_RUNNING, 1: state after reset; 1 = RUN, 0 = HALTED.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- run_req, in, 1: resume request.
- halt_req, in, 1: stop request.
- step_req, in, 1: retire exactly one instruction.
- bp_addr, in, NUM_BP*IADDR_W: breakpoint addresses; entry i is at bits [i*IADDR_W +: IADDR_W].
- bp_en, in, NUM_BP: per-breakpoint enable.
- curr_inst_addr, in, IADDR_W: PC from the core.
- curr_inst, in, INST_W: instruction from imem.
- halt, in, 1: core decoded a halt instruction.
- memW, in, 1: core dmem write request.
- write_addr_dmem, in, DADDR_W: dmem write address.
- write_data_dmem, in, DATA_W: dmem write data.
- pc_enable, out, 1: drives the PC enable.
- dmem_we, out, 1: gated write enable to dmem; equals memW & pc_enable.
- run_state, out, 2: 0 = HALTED, 1 = RUN, 2 = STEP.
- halt_cause, out, 2: 0 = none, 1 = request/step, 2 = breakpoint, 3 = halt instruction.
- retired_count, out, CNT_W: retired instructions, wraps.
- trace_valid, out, 1: trace head entry available.
- trace_ready, in, 1: consumer accepts the head entry.
- trace_addr, out, IADDR_W: head entry, instruction address.
- trace_inst, out, INST_W: head entry, instruction.
- trace_wr, out, 1: head entry performed a dmem write.
- trace_wr_addr, out, DADDR_W: head entry, write address.
- trace_wr_data, out, DATA_W: head entry, write data.
- trace_level, out, log2(TRACE_DEPTH)+1: entries held.
- trace_overflow, out, 1: sticky; set when an entry was overwritten.
- trace_clear, in, 1: empty the buffer and clear trace_overflow.

Behaviour:
- Reset (synchronous, takes priority over all other inputs):
  - run_state = RUN if START_RUNNING, else HALTED.
  - halt_cause = 0, retired_count = 0, trace buffer empty, trace_overflow = 0, skip = 0.
- Breakpoint match (combinational): bp_hit = OR over i of (bp_en[i] && bp_addr[i] == curr_inst_addr) && !skip.
- pc_enable = (RUN && !bp_hit) || STEP. This is the only combinational path from inputs to pc_enable.
- A cycle with pc_enable = 1 retires curr_inst:
  - retired_count increments by 1.
  - One trace entry is pushed: {curr_inst_addr, curr_inst, memW, write_addr_dmem, write_data_dmem}.
  - skip clears.
- FSM transitions, evaluated at each clock edge:
  - HALTED: step_req → STEP, skip = 1. Otherwise run_req → RUN, skip = 1, halt_cause = 0. If both are asserted, step wins. halt_req has no effect.
  - RUN, priority order:
    1. halt_req → HALTED, cause 1. The current cycle still retires if pc_enable = 1.
    2. bp_hit → HALTED, cause 2. The matched instruction is not retired.
    3. Retiring an instruction with halt = 1 → HALTED, cause 3. The halt instruction is traced and counted.
  - STEP: always → HALTED next cycle, cause 3 if halt = 1, otherwise cause 1. Breakpoints are ignored in STEP.
- skip guarantees that resuming from a breakpoint executes the breakpoint instruction once instead of re-halting.
- While HALTED: pc_enable = 0 and dmem_we = 0. The core keeps computing, but no architectural state changes.
- Trace buffer (circular, write pointer, read pointer, level):
  - trace_valid = (level != 0). Outputs show the head entry and are undefined when empty.
  - Pop occurs when trace_valid && trace_ready.
  - Push and pop in the same cycle: both happen and level is unchanged, including when full.
  - Push while full without pop: the oldest entry is overwritten, the read pointer advances, level stays TRACE_DEPTH, trace_overflow is set.
  - Pop while empty is ignored.
  - trace_clear: level = 0, pointers equal, overflow = 0. It overrides a same-cycle push or pop. retired_count is unaffected.
  - Pointers wrap modulo TRACE_DEPTH.
- retired_count wraps from 2^CNT_W - 1 to 0.

Test Plan:
- Reset with START_RUNNING = 1, no requests, 5 cycles:
  - Required: pc_enable = 1 every cycle, retired_count = 5, trace_level = 5.
  - Pops return addresses in retire order, e.g. 0, 1, 2, 3, 4.
- Breakpoint: bp_en = 01, bp_addr[0] = 3.
  - Required: halts with PC = 3 and cause 2; retired_count = 3; address 3 is not traced.
  - Then run_req: address 3 retires once, execution continues, and the core halts again at the next pass through 3.
- Single step from HALTED at PC = 3 with the breakpoint on 3:
  - Required: exactly one retire; pc_enable is high for 1 cycle; the cycle has run_state = STEP, then HALTED with cause 1.
  - A memW = 1 instruction executed while HALTED gives dmem_we = 0 and no trace entry.
- Halt instruction at address 7:
  - Required: the entry for address 7 is traced; cause 3; run_state = HALTED the following cycle.
  - halt_req and bp in the same RUN cycle: cause 1.
- Overflow (TRACE_DEPTH = 16): 20 retires with trace_ready = 0.
  - Required: level = 16, trace_overflow = 1, first pop returns entry 5 (the 5th retire is the oldest kept).
  - Full push plus pop in the same cycle: overflow unchanged, level stays 16.
- Mid-run reset with trace_level = 9 and RUN state:
  - Required: next cycle trace_valid = 0, retired_count = 0, halt_cause = 0, run_state per START_RUNNING.
  - trace_clear asserted with a simultaneous push leaves level = 0.

Source files
------------

// File: rtl/trace_run_ctrl_if.sv
// Trace drain port of trace_run_ctrl.
//   master (trace_run_ctrl): drives the head entry and trace_valid, samples trace_ready.
//   slave  (consumer)      : samples the head entry, drives trace_ready.
// An entry is consumed on a cycle where trace_valid && trace_ready.
interface trace_run_ctrl_if #(
  parameter int IADDR_W = 5,
  parameter int INST_W  = 16,
  parameter int DADDR_W = 4,
  parameter int DATA_W  = 8
);
  logic               trace_valid;
  logic               trace_ready;
  logic [IADDR_W-1:0] trace_addr;
  logic [INST_W-1:0]  trace_inst;
  logic               trace_wr;
  logic [DADDR_W-1:0] trace_wr_addr;
  logic [DATA_W-1:0]  trace_wr_data;

  modport master (
    output trace_valid, trace_addr, trace_inst, trace_wr, trace_wr_addr, trace_wr_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_addr, trace_inst, trace_wr, trace_wr_addr, trace_wr_data,
    output trace_ready
  );
endinterface

// File: rtl/trace_run_ctrl.sv
// Run control and instruction trace for the single-cycle core.
// A HALTED/RUN/STEP state machine with address breakpoints drives the PC enable
// and gates the dmem write enable. Every retired instruction (a cycle with
// pc_enable = 1) bumps retired_count and pushes one entry into a circular trace
// buffer that is drained through the trace interface.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   run_req/halt_req/step_req  : run-control requests
//   bp_addr, bp_en             : breakpoint comparators (entry i at bits [i*IADDR_W +: IADDR_W])
//   curr_inst_addr, curr_inst  : PC and instruction of the current cycle
//   halt                       : core decoded a halt instruction
//   memW, write_addr_dmem, write_data_dmem : core dmem write request
//   pc_enable, dmem_we         : PC enable and gated dmem write enable
//   run_state, halt_cause      : 0/1/2 = HALTED/RUN/STEP; 0 none, 1 request/step, 2 bp, 3 halt inst
//   retired_count              : wrapping retired-instruction counter
//   trace (master)             : head entry + valid/ready
//   trace_level, trace_overflow, trace_clear : buffer fill, sticky overwrite flag, clear
module trace_run_ctrl #(
  parameter int IADDR_W       = 5,
  parameter int INST_W        = 16,
  parameter int DADDR_W       = 4,
  parameter int DATA_W        = 8,
  parameter int TRACE_DEPTH   = 16,
  parameter int NUM_BP        = 2,
  parameter int CNT_W         = 16,
  parameter int START_RUNNING = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run_req,
  input  logic                        halt_req,
  input  logic                        step_req,
  input  logic [NUM_BP*IADDR_W-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]           bp_en,
  input  logic [IADDR_W-1:0]          curr_inst_addr,
  input  logic [INST_W-1:0]           curr_inst,
  input  logic                        halt,
  input  logic                        memW,
  input  logic [DADDR_W-1:0]          write_addr_dmem,
  input  logic [DATA_W-1:0]           write_data_dmem,
  output logic                        pc_enable,
  output logic                        dmem_we,
  output logic [1:0]                  run_state,
  output logic [1:0]                  halt_cause,
  output logic [CNT_W-1:0]            retired_count,
  trace_run_ctrl_if.master            trace,
  output logic [$clog2(TRACE_DEPTH):0] trace_level,
  output logic                        trace_overflow,
  input  logic                        trace_clear
);

  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int ENTRY_W = IADDR_W + INST_W + 1 + DADDR_W + DATA_W;
  localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         cause_reg, cause_next;
  logic               skip_reg, skip_next;
  logic [CNT_W-1:0]   count_reg;

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]     level_reg, level_next;
  logic               ovf_reg, ovf_next;
  logic [ENTRY_W-1:0] trace_mem [TRACE_DEPTH];
  logic [ENTRY_W-1:0] head_reg;
  logic [ENTRY_W-1:0] push_entry;
  logic               push, pop;

  // ---------------- breakpoints ----------------
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit;

  generate
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign bp_match[gi] = bp_en[gi] && (bp_addr[gi*IADDR_W +: IADDR_W] == curr_inst_addr);
    end
  endgenerate

  // skip masks the breakpoint for the first instruction after a resume, so the
  // instruction we stopped on executes once instead of re-halting forever.
  assign bp_hit    = (|bp_match) && !skip_reg;
  assign pc_enable = ((state_reg == ST_RUN) && !bp_hit) || (state_reg == ST_STEP);
  assign dmem_we   = memW & pc_enable;

  // ---------------- run-control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= (START_RUNNING != 0) ? ST_RUN : ST_HALTED;
      cause_reg <= 2'd0;
      skip_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      skip_reg  <= skip_next;
      if (pc_enable) count_reg <= count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    skip_next  = skip_reg;
    if (pc_enable) skip_next = 1'b0;
    case (state_reg)
      ST_HALTED: begin
        if (step_req) begin
          state_next = ST_STEP;
          skip_next  = 1'b1;
        end else if (run_req) begin
          state_next = ST_RUN;
          skip_next  = 1'b1;
          cause_next = 2'd0;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_next = ST_HALTED;
          cause_next = 2'd1;
        end else if (bp_hit) begin
          state_next = ST_HALTED;
          cause_next = 2'd2;
        end else if (halt) begin
          // Reaching here in RUN means pc_enable is high: the halt instruction retires.
          state_next = ST_HALTED;
          cause_next = 2'd3;
        end
      end
      ST_STEP: begin
        state_next = ST_HALTED;
        cause_next = halt ? 2'd3 : 2'd1;
      end
      default: state_next = ST_HALTED;
    endcase
  end

  assign run_state     = state_reg;
  assign halt_cause    = cause_reg;
  assign retired_count = count_reg;

  // ---------------- trace buffer ----------------
  assign push       = pc_enable;
  assign pop        = (level_reg != '0) && trace.trace_ready;
  assign push_entry = {curr_inst_addr, curr_inst, memW, write_addr_dmem, write_data_dmem};

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    ovf_next    = ovf_reg;
    if (trace_clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      ovf_next    = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop) begin
        if (level_reg == LEVEL_FULL) begin
          // Full: the new entry lands on the oldest slot, so the head moves past it.
          rd_ptr_next = rd_ptr_reg + PTR_W'(1);
          ovf_next    = 1'b1;
        end else begin
          level_next = level_reg + (PTR_W + 1)'(1);
        end
      end else if (pop && !push) begin
        level_next = level_reg - (PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      ovf_reg    <= ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) trace_mem[wr_ptr_reg] <= push_entry;
  end

  // Registered read of the next head. The only slot that changes this edge is
  // wr_ptr_reg, so forwarding the pushed entry when it lands on the next head
  // keeps the head register equal to the post-edge memory contents.
  always_ff @(posedge clk) begin
    if (push && (wr_ptr_reg == rd_ptr_next)) head_reg <= push_entry;
    else                                     head_reg <= trace_mem[rd_ptr_next];
  end

  assign trace.trace_valid   = (level_reg != '0);
  assign trace.trace_addr    = head_reg[ENTRY_W-1 -: IADDR_W];
  assign trace.trace_inst    = head_reg[ENTRY_W-IADDR_W-1 -: INST_W];
  assign trace.trace_wr      = head_reg[DADDR_W+DATA_W];
  assign trace.trace_wr_addr = head_reg[DATA_W +: DADDR_W];
  assign trace.trace_wr_data = head_reg[DATA_W-1:0];
  assign trace_level         = level_reg;
  assign trace_overflow      = ovf_reg;

endmodule

// File: tb/tb_trace_run_ctrl.sv
module tb_trace_run_ctrl;
  localparam int IADDR_W = 5, INST_W = 16, DADDR_W = 4, DATA_W = 8;
  localparam int TRACE_DEPTH = 16, NUM_BP = 2, CNT_W = 16, START_RUNNING = 1;
  localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run_req, halt_req, step_req, halt, memW, trace_clear;
  logic [NUM_BP*IADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0] bp_en;
  logic [IADDR_W-1:0] curr_inst_addr;
  logic [INST_W-1:0] curr_inst;
  logic [DADDR_W-1:0] write_addr_dmem;
  logic [DATA_W-1:0] write_data_dmem;
  logic pc_enable, dmem_we, trace_overflow;
  logic [1:0] run_state, halt_cause;
  logic [CNT_W-1:0] retired_count;
  logic [LVL_W-1:0] trace_level;

  trace_run_ctrl_if #(.IADDR_W(IADDR_W), .INST_W(INST_W), .DADDR_W(DADDR_W), .DATA_W(DATA_W)) trace_bus ();

  trace_run_ctrl #(
    .IADDR_W(IADDR_W), .INST_W(INST_W), .DADDR_W(DADDR_W), .DATA_W(DATA_W),
    .TRACE_DEPTH(TRACE_DEPTH), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .START_RUNNING(START_RUNNING)
  ) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .bp_addr(bp_addr), .bp_en(bp_en), .curr_inst_addr(curr_inst_addr), .curr_inst(curr_inst),
    .halt(halt), .memW(memW), .write_addr_dmem(write_addr_dmem), .write_data_dmem(write_data_dmem),
    .pc_enable(pc_enable), .dmem_we(dmem_we), .run_state(run_state), .halt_cause(halt_cause),
    .retired_count(retired_count), .trace(trace_bus), .trace_level(trace_level),
    .trace_overflow(trace_overflow), .trace_clear(trace_clear)
  );

  typedef struct packed {
    logic [IADDR_W-1:0] addr;
    logic [INST_W-1:0]  inst;
    logic               wr;
    logic [DADDR_W-1:0] wa;
    logic [DATA_W-1:0]  wd;
  } entry_t;

  // Reference model: run state as small ints, trace as a queue of entries.
  int m_state, m_cause;
  bit m_skip, m_ovf;
  logic [CNT_W-1:0] m_count;
  entry_t m_trace[$];
  logic [IADDR_W-1:0] pc = '0;
  bit halt_en = 0;
  logic [IADDR_W-1:0] halt_at = '0;
  bit exp_bp, exp_pc_en, exp_we;
  int checks = 0, errors = 0;

  function automatic logic [INST_W-1:0] inst_of(logic [IADDR_W-1:0] a);
    return 16'hC000 | {6'h0, a, a};
  endfunction

  task drive_core();
    curr_inst_addr = pc;
    curr_inst      = inst_of(pc);
    halt           = halt_en && (pc == halt_at);
  endtask

  function void model_comb();
    exp_bp = 0;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i] && bp_addr[i*IADDR_W +: IADDR_W] == pc) exp_bp = 1;
    if (m_skip) exp_bp = 0;
    exp_pc_en = (m_state == 1 && !exp_bp) || m_state == 2;
    exp_we = memW && exp_pc_en;
  endfunction

  task settle();
    #1;
    model_comb();
  endtask

  task tick();
    entry_t e;
    bit pop_ok;
    model_comb();
    if (reset) begin
      m_state = START_RUNNING ? 1 : 0;
      m_cause = 0; m_skip = 0; m_count = '0; m_ovf = 0; pc = '0;
      m_trace.delete();
    end else begin
      pop_ok = (m_trace.size() > 0) && trace_bus.trace_ready;
      if (trace_clear) begin
        m_trace.delete();
        m_ovf = 0;
      end else begin
        if (pop_ok) void'(m_trace.pop_front());
        if (exp_pc_en) begin
          e.addr = pc; e.inst = inst_of(pc); e.wr = memW; e.wa = write_addr_dmem; e.wd = write_data_dmem;
          m_trace.push_back(e);
          if (m_trace.size() > TRACE_DEPTH) begin
            void'(m_trace.pop_front());
            m_ovf = 1;
          end
        end
      end
      if (exp_pc_en) begin
        m_count = m_count + 1'b1;
        m_skip = 0;
      end
      case (m_state)
        0: if (step_req) begin m_state = 2; m_skip = 1; end
           else if (run_req) begin m_state = 1; m_skip = 1; m_cause = 0; end
        1: if (halt_req) begin m_state = 0; m_cause = 1; end
           else if (exp_bp) begin m_state = 0; m_cause = 2; end
           else if (halt) begin m_state = 0; m_cause = 3; end
        default: begin m_cause = halt ? 3 : 1; m_state = 0; end
      endcase
      if (exp_pc_en) pc = pc + 1'b1;
    end
    @(posedge clk);
    #1;
    drive_core();
  endtask

  task do_reset();
    run_req = 0; halt_req = 0; step_req = 0; trace_clear = 0; memW = 0;
    write_addr_dmem = '0; write_data_dmem = '0; trace_bus.trace_ready = 0;
    bp_en = '0; bp_addr = '0; halt_en = 0; halt_at = '0;
    reset = 1;
    drive_core();
    tick();
    reset = 0;
  endtask

  task test_reset();
    do_reset();
    settle();
    checks++; if (run_state !== 2'd1) begin errors++; $display("FAIL reset_state: got %0d want 1", run_state); end
    checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", halt_cause); end
    checks++; if (retired_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    checks++; if (trace_bus.trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", trace_bus.trace_valid); end
    checks++; if (trace_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", trace_overflow); end
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL run_pc_enable: cycle %0d got %0b want 1", c, pc_enable); end
      tick();
    end
    settle();
    checks++; if (retired_count !== 16'd5) begin errors++; $display("FAIL run_count: got %0d want 5", retired_count); end
    checks++; if (trace_level !== 5'd5) begin errors++; $display("FAIL run_level: got %0d want 5", trace_level); end
    trace_bus.trace_ready = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      $display("pop addr=%0d inst=%h", trace_bus.trace_addr, trace_bus.trace_inst);
      checks++; if (trace_bus.trace_addr !== 5'(i)) begin errors++; $display("FAIL pop_order: got %0d want %0d", trace_bus.trace_addr, i); end
      tick();
    end
    trace_bus.trace_ready = 0;
  endtask

  task wait_model_halt(input int budget, input string tag);
    int n;
    n = 0;
    while (m_state != 0 && n < budget) begin
      settle();
      checks++; if (pc_enable !== exp_pc_en) begin errors++; $display("FAIL %s_pc_enable: got %0b want %0b", tag, pc_enable, exp_pc_en); end
      tick();
      n++;
    end
    checks++; if (m_state != 0) begin errors++; $display("FAIL %s_timeout: got running after %0d cycles want halted", tag, n); end
  endtask

  task test_breakpoint();
    do_reset();
    bp_addr = {5'd0, 5'd3}; bp_en = 2'b01;
    wait_model_halt(50, "bp1");
    settle();
    checks++; if (run_state !== 2'd0) begin errors++; $display("FAIL bp_state: got %0d want 0", run_state); end
    checks++; if (halt_cause !== 2'd2) begin errors++; $display("FAIL bp_cause: got %0d want 2", halt_cause); end
    checks++; if (retired_count !== 16'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", retired_count); end
    checks++; if (trace_level !== 5'd3) begin errors++; $display("FAIL bp_level: got %0d want 3", trace_level); end
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL bp_pc_enable: got %0b want 0", pc_enable); end
    trace_bus.trace_ready = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      $display("pop addr=%0d", trace_bus.trace_addr);
      checks++; if (trace_bus.trace_addr !== 5'(i)) begin errors++; $display("FAIL bp_pop: got %0d want %0d", trace_bus.trace_addr, i); end
      tick();
    end
    run_req = 1;
    tick();
    run_req = 0;
    settle();
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL bp_resume: got %0b want 1", pc_enable); end
    checks++; if (trace_level !== 5'd0) begin errors++; $display("FAIL bp_not_traced: level %0d want 0", trace_level); end
    wait_model_halt(100, "bp2");
    settle();
    checks++; if (halt_cause !== 2'd2) begin errors++; $display("FAIL bp2_cause: got %0d want 2", halt_cause); end
    checks++; if (retired_count !== 16'd35) begin errors++; $display("FAIL bp2_count: got %0d want 35", retired_count); end
  endtask

  task test_single_step();
    // Continues from the breakpoint stop at PC 3.
    memW = 1; write_addr_dmem = 4'd5; write_data_dmem = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL halted_we: got %0b want 0", dmem_we); end
      tick();
    end
    trace_bus.trace_ready = 0;
    settle();
    checks++; if (trace_level !== 5'd0) begin errors++; $display("FAIL halted_no_trace: level %0d want 0", trace_level); end
    step_req = 1;
    tick();
    step_req = 0;
    settle();
    checks++; if (run_state !== 2'd2) begin errors++; $display("FAIL step_state: got %0d want 2", run_state); end
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL step_pc_enable: got %0b want 1", pc_enable); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL step_we: got %0b want 1", dmem_we); end
    tick();
    settle();
    checks++; if (run_state !== 2'd0) begin errors++; $display("FAIL step_halted: got %0d want 0", run_state); end
    checks++; if (halt_cause !== 2'd1) begin errors++; $display("FAIL step_cause: got %0d want 1", halt_cause); end
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL step_one_cycle: got %0b want 0", pc_enable); end
    checks++; if (retired_count !== 16'd36) begin errors++; $display("FAIL step_count: got %0d want 36", retired_count); end
    $display("step entry addr=%0d wr=%0b wa=%0d wd=%h", trace_bus.trace_addr, trace_bus.trace_wr, trace_bus.trace_wr_addr, trace_bus.trace_wr_data);
    checks++; if ({trace_level, trace_bus.trace_addr, trace_bus.trace_wr, trace_bus.trace_wr_addr, trace_bus.trace_wr_data} !== {5'd1, 5'd3, 1'b1, 4'd5, 8'hAA})
      begin errors++; $display("FAIL step_entry: got lvl %0d addr %0d wr %0b wa %0d wd %h want 1 3 1 5 aa", trace_level, trace_bus.trace_addr, trace_bus.trace_wr, trace_bus.trace_wr_addr, trace_bus.trace_wr_data); end
    memW = 0;
  endtask

  task test_halt_inst();
    do_reset();
    halt_en = 1; halt_at = 5'd7;
    drive_core();
    wait_model_halt(50, "hinst");
    settle();
    checks++; if (run_state !== 2'd0) begin errors++; $display("FAIL hinst_state: got %0d want 0", run_state); end
    checks++; if (halt_cause !== 2'd3) begin errors++; $display("FAIL hinst_cause: got %0d want 3", halt_cause); end
    checks++; if (trace_level !== 5'd8) begin errors++; $display("FAIL hinst_level: got %0d want 8", trace_level); end
    trace_bus.trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      $display("pop addr=%0d", trace_bus.trace_addr);
      checks++; if (trace_bus.trace_addr !== 5'(i)) begin errors++; $display("FAIL hinst_pop: got %0d want %0d", trace_bus.trace_addr, i); end
      tick();
    end
    halt_en = 0; bp_addr = {5'd0, 5'd9}; bp_en = 2'b01;
    drive_core();
    run_req = 1;
    tick();
    run_req = 0;
    tick();
    halt_req = 1;
    settle();
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL hreq_bp_pc_enable: got %0b want 0", pc_enable); end
    tick();
    halt_req = 0;
    settle();
    checks++; if (halt_cause !== 2'd1) begin errors++; $display("FAIL hreq_bp_cause: got %0d want 1", halt_cause); end
    checks++; if (retired_count !== 16'd9) begin errors++; $display("FAIL hreq_bp_count: got %0d want 9", retired_count); end
  endtask

  task test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    settle();
    checks++; if (trace_level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", trace_level); end
    checks++; if (trace_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", trace_overflow); end
    checks++; if (trace_bus.trace_addr !== 5'd4) begin errors++; $display("FAIL ovf_head: got %0d want 4", trace_bus.trace_addr); end
    trace_bus.trace_ready = 1;
    tick();
    trace_bus.trace_ready = 0;
    settle();
    checks++; if (trace_level !== 5'd16) begin errors++; $display("FAIL full_pushpop_level: got %0d want 16", trace_level); end
    checks++; if (trace_overflow !== 1'b1) begin errors++; $display("FAIL full_pushpop_ovf: got %0b want 1", trace_overflow); end
    checks++; if (trace_bus.trace_addr !== 5'd5) begin errors++; $display("FAIL full_pushpop_head: got %0d want 5", trace_bus.trace_addr); end
  endtask

  task test_midrun_reset();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    settle();
    checks++; if (trace_level !== 5'd9) begin errors++; $display("FAIL mid_level: got %0d want 9", trace_level); end
    reset = 1;
    tick();
    reset = 0;
    settle();
    checks++; if (trace_bus.trace_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", trace_bus.trace_valid); end
    checks++; if (retired_count !== '0) begin errors++; $display("FAIL mid_count: got %0d want 0", retired_count); end
    checks++; if (halt_cause !== 2'd0 || run_state !== 2'd1) begin errors++; $display("FAIL mid_state: got cause %0d state %0d want 0 1", halt_cause, run_state); end
    for (int i = 0; i < 3; i++) tick();
    trace_clear = 1;
    settle();
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL clear_push: got %0b want 1", pc_enable); end
    tick();
    trace_clear = 0;
    settle();
    checks++; if (trace_level !== 5'd0) begin errors++; $display("FAIL clear_level: got %0d want 0", trace_level); end
    checks++; if (retired_count !== 16'd4) begin errors++; $display("FAIL clear_count: got %0d want 4", retired_count); end
  endtask

  task test_random();
    entry_t got;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      run_req  = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 11) == 0);
      step_req = ($urandom_range(0, 7) == 0);
      memW = 1'($urandom); write_addr_dmem = 4'($urandom); write_data_dmem = 8'($urandom);
      trace_bus.trace_ready = ($urandom_range(0, 2) != 0);
      trace_clear = ($urandom_range(0, 80) == 0);
      reset = ($urandom_range(0, 250) == 0);
      if (c % 40 == 0) begin bp_en = 2'($urandom); bp_addr = 10'($urandom); end
      if (c % 55 == 0) begin halt_en = 1'($urandom); halt_at = 5'($urandom); end
      drive_core();
      settle();
      checks++; if (pc_enable !== exp_pc_en || dmem_we !== exp_we) begin errors++; $display("FAIL rnd_enables: cycle %0d got pc_en %0b we %0b want %0b %0b", c, pc_enable, dmem_we, exp_pc_en, exp_we); end
      checks++; if (run_state !== 2'(m_state) || halt_cause !== 2'(m_cause)) begin errors++; $display("FAIL rnd_state: cycle %0d got state %0d cause %0d want %0d %0d", c, run_state, halt_cause, m_state, m_cause); end
      checks++; if (retired_count !== m_count) begin errors++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", c, retired_count, m_count); end
      checks++; if (trace_level !== LVL_W'(m_trace.size()) || trace_overflow !== m_ovf) begin errors++; $display("FAIL rnd_level: cycle %0d got lvl %0d ovf %0b want %0d %0b", c, trace_level, trace_overflow, m_trace.size(), m_ovf); end
      checks++; if (trace_bus.trace_valid !== (m_trace.size() != 0)) begin errors++; $display("FAIL rnd_valid: cycle %0d got %0b want %0b", c, trace_bus.trace_valid, m_trace.size() != 0); end
      if (m_trace.size() != 0) begin
        got = {trace_bus.trace_addr, trace_bus.trace_inst, trace_bus.trace_wr, trace_bus.trace_wr_addr, trace_bus.trace_wr_data};
        checks++; if (got !== m_trace[0]) begin errors++; $display("FAIL rnd_head: cycle %0d got %h want %h", c, got, m_trace[0]); end
      end
      tick();
    end
    reset = 0; trace_clear = 0;
  endtask

  initial begin
    test_reset();
    test_breakpoint();
    test_single_step();
    test_halt_inst();
    test_overflow();
    test_midrun_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
